// File: rtl/uart_loader_pkg.sv
// Shared types and defaults for the UART image loader.
// State encoding, widths and the slot base helper.
package uart_loader_pkg;

   localparam int ADDR_W = 23;
   localparam int CNT_W  = 19;

   localparam int unsigned       PIXELS_DEF = 307200;
   localparam logic [ADDR_W-1:0] STRIDE_DEF = 23'h04B000;
   localparam logic [7:0]        SYNC_DEF   = 8'hA5;

   typedef enum logic [1:0] {
      IDLE,
      SLOT,
      DATA
   } state_t;

   // Slot base is a plain constant multiply, truncated to the address width.
   function automatic logic [ADDR_W-1:0] slot_base(
      input logic [2:0]        slot,
      input logic [ADDR_W-1:0] stride
   );
      return stride * ADDR_W'(slot);
   endfunction

endpackage

// File: rtl/loader_gap_timer.sv
// Inter-byte gap timer for the UART image loader.
// Counts idle cycles while enabled; expire flags the last allowed cycle.
module loader_gap_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 5_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic expire
);

   localparam int unsigned W =
      (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

   logic [W-1:0] cnt_q;

   // Gap count: held at zero when disabled or on a byte, saturates at LAST.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (clr || !en) begin
         cnt_q <= '0;
      end else if (cnt_q != LAST) begin
         cnt_q <= cnt_q + W'(1);
      end
   end

   assign expire = en && (cnt_q == LAST);

endmodule

// File: rtl/uart_image_loader.sv
// Framed UART byte stream to SDRAM write port: sync, slot, pixels.
// Every output is registered one cycle after the byte that caused it.
module uart_image_loader
   import uart_loader_pkg::*;
#(
   parameter int unsigned       PIXELS_PER_FRAME = PIXELS_DEF,
   parameter int unsigned       NUM_SLOTS        = 5,
   parameter logic [ADDR_W-1:0] SLOT_STRIDE      = STRIDE_DEF,
   parameter logic [7:0]        SYNC_BYTE        = SYNC_DEF,
   parameter int unsigned       TIMEOUT_CYCLES   = 5_000_000
) (
   input  logic              iCLK,
   input  logic              iRST,
   input  logic [7:0]        iRX_DATA,
   input  logic              iRX_VALID,
   output logic [15:0]       oWR_DATA,
   output logic              oWR_EN,
   output logic [ADDR_W-1:0] oWR_ADDR,
   output logic [2:0]        oSLOT,
   output logic [CNT_W-1:0]  oPIX_CNT,
   output logic              oBUSY,
   output logic              oFRAME_DONE,
   output logic              oERR
);

   localparam logic [7:0]       NSLOT    = 8'(NUM_SLOTS);
   localparam logic [CNT_W-1:0] PIX_LAST = CNT_W'(PIXELS_PER_FRAME - 1);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   base_q, base_d;
   logic [CNT_W-1:0]    pix_d;
   logic [2:0]          slot_d;
   logic [15:0]         wr_data_d;
   logic [ADDR_W-1:0]   wr_addr_d;
   logic                wr_en_d;
   logic                done_d;
   logic                err_d;
   logic                expire;

   loader_gap_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_gap (
      .clk   (iCLK),
      .rst   (iRST),
      .en    (state_q != IDLE),
      .clr   (iRX_VALID),
      .expire(expire)
   );

   // Frame parser: a received byte always takes priority over a timeout.
   always_comb begin
      state_d   = state_q;
      base_d    = base_q;
      pix_d     = oPIX_CNT;
      slot_d    = oSLOT;
      wr_data_d = oWR_DATA;
      wr_addr_d = oWR_ADDR;
      wr_en_d   = 1'b0;
      done_d    = 1'b0;
      err_d     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (iRX_VALID && iRX_DATA == SYNC_BYTE) begin
               state_d = SLOT;
            end
         end
         SLOT: begin
            if (iRX_VALID) begin
               if (iRX_DATA < NSLOT) begin
                  slot_d  = iRX_DATA[2:0];
                  base_d  = slot_base(iRX_DATA[2:0], SLOT_STRIDE);
                  pix_d   = '0;
                  state_d = DATA;
               end else begin
                  err_d   = 1'b1;
                  state_d = IDLE;
               end
            end else if (expire) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end
         end
         DATA: begin
            if (iRX_VALID) begin
               wr_en_d   = 1'b1;
               wr_data_d = {8'h00, iRX_DATA};
               wr_addr_d = base_q + ADDR_W'(oPIX_CNT);
               pix_d     = oPIX_CNT + CNT_W'(1);
               if (oPIX_CNT == PIX_LAST) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end
            end else if (expire) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and registered outputs; reset abandons any partial frame.
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         state_q     <= IDLE;
         base_q      <= '0;
         oPIX_CNT    <= '0;
         oSLOT       <= '0;
         oWR_DATA    <= '0;
         oWR_ADDR    <= '0;
         oWR_EN      <= 1'b0;
         oFRAME_DONE <= 1'b0;
         oERR        <= 1'b0;
         oBUSY       <= 1'b0;
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         oPIX_CNT    <= pix_d;
         oSLOT       <= slot_d;
         oWR_DATA    <= wr_data_d;
         oWR_ADDR    <= wr_addr_d;
         oWR_EN      <= wr_en_d;
         oFRAME_DONE <= done_d;
         oERR        <= err_d;
         oBUSY       <= (state_d != IDLE);
      end
   end

endmodule

// File: tb/tb_uart_image_loader.sv
// Directed bench for uart_image_loader with a write scoreboard.
// Small frames (4 pixels) and a 16-cycle timeout.
module tb_uart_image_loader;

   logic        iCLK = 1'b0;
   logic        iRST = 1'b1;
   logic [7:0]  iRX_DATA = 8'h00;
   logic        iRX_VALID = 1'b0;
   logic [15:0] oWR_DATA;
   logic        oWR_EN;
   logic [22:0] oWR_ADDR;
   logic [2:0]  oSLOT;
   logic [18:0] oPIX_CNT;
   logic        oBUSY;
   logic        oFRAME_DONE;
   logic        oERR;

   int compared   = 0;
   int mismatched = 0;
   int err_cnt    = 0;
   int done_cnt   = 0;
   int rd         = 0;

   logic [39:0] exp_q[$];
   logic [39:0] obs_q[$];

   uart_image_loader #(
      .PIXELS_PER_FRAME(4),
      .TIMEOUT_CYCLES  (16)
   ) dut (
      .iCLK       (iCLK),
      .iRST       (iRST),
      .iRX_DATA   (iRX_DATA),
      .iRX_VALID  (iRX_VALID),
      .oWR_DATA   (oWR_DATA),
      .oWR_EN     (oWR_EN),
      .oWR_ADDR   (oWR_ADDR),
      .oSLOT      (oSLOT),
      .oPIX_CNT   (oPIX_CNT),
      .oBUSY      (oBUSY),
      .oFRAME_DONE(oFRAME_DONE),
      .oERR       (oERR)
   );

   always #5 iCLK = ~iCLK;

   // Output monitor: records writes and counts pulses away from the edge.
   always @(negedge iCLK) begin
      if (oWR_EN === 1'b1) obs_q.push_back({oWR_ADDR, oWR_DATA, oFRAME_DONE});
      if (oERR === 1'b1) err_cnt++;
      if (oFRAME_DONE === 1'b1) done_cnt++;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] b, input int gap);
      iRX_DATA  = b;
      iRX_VALID = 1'b1;
      @(negedge iCLK);
      iRX_VALID = 1'b0;
      repeat (gap - 1) @(negedge iCLK);
   endtask

   task automatic pix(input logic [7:0] b, input logic [22:0] a,
                      input logic d, input int gap);
      exp_q.push_back({a, 8'h00, b, d});
      send(b, gap);
   endtask

   task automatic check_writes();
      logic [39:0] e;
      repeat (3) @(negedge iCLK);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (rd < obs_q.size()) begin
            chk("write", obs_q[rd], e);
            rd++;
         end else begin
            chk("write_missing", obs_q.size(), rd + 1);
         end
      end
      chk("extra_writes", obs_q.size(), rd);
   endtask

   task automatic wait_err(input int e0);
      for (int i = 0; i < 40 && err_cnt == e0; i++) @(negedge iCLK);
      chk("err_pulse", err_cnt, e0 + 1);
   endtask

   initial begin
      int e0;
      repeat (2) @(negedge iCLK);
      iRST = 1'b0;
      @(negedge iCLK);
      chk("reset_wr", {oWR_DATA, oWR_ADDR, oWR_EN}, 64'h0);
      chk("reset_st", {oSLOT, oPIX_CNT, oBUSY, oFRAME_DONE, oERR}, 64'h0);

      // Slot 2 frame
      send(8'hA5, 3);
      send(8'h02, 3);
      chk("busy_in_data", oBUSY, 1'b1);
      pix(8'h11, 23'h096000, 1'b0, 3);
      pix(8'h22, 23'h096001, 1'b0, 3);
      pix(8'h33, 23'h096002, 1'b0, 3);
      pix(8'h44, 23'h096003, 1'b1, 3);
      check_writes();
      chk("f1_slot", oSLOT, 3'd2);
      chk("f1_cnt", oPIX_CNT, 19'd4);
      chk("f1_busy", oBUSY, 1'b0);
      chk("f1_err", err_cnt, 0);

      // Garbage before sync, slot 0
      send(8'h00, 3);
      send(8'h7F, 3);
      chk("garbage_busy", oBUSY, 1'b0);
      send(8'hA5, 3);
      send(8'h00, 3);
      pix(8'hAA, 23'h000000, 1'b0, 3);
      pix(8'hBB, 23'h000001, 1'b0, 3);
      pix(8'hCC, 23'h000002, 1'b0, 3);
      pix(8'hDD, 23'h000003, 1'b1, 3);
      check_writes();
      chk("f2_err", err_cnt, 0);

      // Bad slot
      e0 = err_cnt;
      send(8'hA5, 3);
      send(8'h05, 3);
      wait_err(e0);
      repeat (3) @(negedge iCLK);
      chk("badslot_once", err_cnt, e0 + 1);
      chk("badslot_nowr", obs_q.size(), rd);
      chk("badslot_busy", oBUSY, 1'b0);
      send(8'hA5, 3);
      send(8'h01, 3);
      pix(8'h01, 23'h04B000, 1'b0, 3);
      pix(8'h02, 23'h04B001, 1'b0, 3);
      pix(8'hA5, 23'h04B002, 1'b0, 3);
      pix(8'h04, 23'h04B003, 1'b1, 3);
      check_writes();

      // Timeout after one pixel
      send(8'hA5, 3);
      send(8'h03, 3);
      e0 = err_cnt;
      pix(8'h10, 23'h0E1000, 1'b0, 3);
      wait_err(e0);
      check_writes();
      chk("to_busy", oBUSY, 1'b0);
      chk("to_cnt", oPIX_CNT, 19'd1);
      chk("to_slot", oSLOT, 3'd3);
      send(8'hA5, 3);
      send(8'h03, 3);
      pix(8'h20, 23'h0E1000, 1'b0, 3);
      pix(8'h21, 23'h0E1001, 1'b0, 3);
      pix(8'h22, 23'h0E1002, 1'b0, 3);
      pix(8'h23, 23'h0E1003, 1'b1, 3);
      check_writes();

      // Reset mid-transfer
      send(8'hA5, 3);
      send(8'h04, 3);
      pix(8'h31, 23'h12C000, 1'b0, 3);
      pix(8'h32, 23'h12C001, 1'b0, 3);
      chk("mid_busy", oBUSY, 1'b1);
      chk("mid_cnt", oPIX_CNT, 19'd2);
      #2 iRST = 1'b1;
      #1;
      chk("arst_wr", {oWR_DATA, oWR_ADDR, oWR_EN}, 64'h0);
      chk("arst_st", {oSLOT, oPIX_CNT, oBUSY, oFRAME_DONE, oERR}, 64'h0);
      @(negedge iCLK);
      iRST = 1'b0;
      check_writes();
      send(8'hA5, 3);
      send(8'h04, 3);
      pix(8'h41, 23'h12C000, 1'b0, 3);
      pix(8'h42, 23'h12C001, 1'b0, 3);
      pix(8'h43, 23'h12C002, 1'b0, 3);
      pix(8'h44, 23'h12C003, 1'b1, 3);
      check_writes();
      chk("f5_slot", oSLOT, 3'd4);

      // Bytes landing exactly on the expiry cycle
      e0 = err_cnt;
      send(8'hA5, 3);
      send(8'h00, 16);
      pix(8'h51, 23'h000000, 1'b0, 16);
      pix(8'h52, 23'h000001, 1'b0, 16);
      pix(8'h53, 23'h000002, 1'b0, 3);
      pix(8'h54, 23'h000003, 1'b1, 3);
      check_writes();
      chk("edge_no_err", err_cnt, e0);
      chk("edge_cnt", oPIX_CNT, 19'd4);
      chk("done_total", done_cnt, 6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
